// File: rtl/ddr4_pkg.sv
// Shared DDR4 command decoder types: command codes, bank states and the
// A-bus bit positions that carry RAS_n/CAS_n/WE_n and auto-precharge.
package ddr4_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    ACT  = 3'd1,
    RD   = 3'd2,
    WR   = 3'd3,
    PRE  = 3'd4,
    PREA = 3'd5,
    REF  = 3'd6,
    MRS  = 3'd7
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } bank_state_t;

  localparam int RAS_BIT = 16;
  localparam int CAS_BIT = 15;
  localparam int WE_BIT  = 14;
  localparam int AP_BIT  = 10;

endpackage

// File: rtl/ddr4_cmd_decoder_if.sv
// Controller-side CA bus of one DDR4 rank. The controller (or bench) drives
// the master modport; the decoder samples through the slave modport.
interface ddr4_cmd_decoder_if #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17
);
  logic                 cke;
  logic                 cs_n;
  logic                 act_n;
  logic [ADDRWIDTH-1:0] A;
  logic [BGWIDTH-1:0]   bg;
  logic [BAWIDTH-1:0]   ba;
  logic                 parity;

  modport master (output cke, cs_n, act_n, A, bg, ba, parity);
  modport slave  (input  cke, cs_n, act_n, A, bg, ba, parity);
endinterface

// File: rtl/ddr4_bank_fsm.sv
// Per-bank row state with a single down-counter shared by tRCD and tRP.
// The state output is the post-expiry view so same-edge commands see it.
//
// state       | meaning
// IDLE        | row closed, ACT legal
// ACTIVATING  | ACT accepted, counting tRCD
// ACTIVE      | row open, RD/WR/PRE legal
// PRECHARGING | PRE or auto-precharge accepted, counting tRP
module ddr4_bank_fsm
  import ddr4_pkg::*;
#(
  parameter int TRCD = 15,
  parameter int TRP  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        act,
  input  logic        pre,
  output bank_state_t state
);

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW   = $clog2(TMAX + 1);

  bank_state_t     st_q, st_d, st_eff;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    st_eff = st_q;
    if (cnt_q == '0) begin
      if (st_q == ACTIVATING)  st_eff = ACTIVE;
      if (st_q == PRECHARGING) st_eff = IDLE;
    end

    st_d  = st_q;
    cnt_d = cnt_q;
    if (en) begin
      st_d = st_eff;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      case (st_eff)
        IDLE: begin
          if (act) begin
            st_d  = ACTIVATING;
            cnt_d = CW'(TRCD - 1);
          end
        end
        ACTIVE: begin
          if (pre) begin
            st_d  = PRECHARGING;
            cnt_d = CW'(TRP - 1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state = st_eff;

endmodule

// File: rtl/ddr4_cmd_decoder.sv
// DDR4 CA-bus responder for one rank: decode, legality checks, refresh timer
// and the single-outstanding column burst scheduler.
// Optional macro DDR4_CA_PARITY_EN adds CA parity checking and parity_err.
module ddr4_cmd_decoder
  import ddr4_pkg::*;
#(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int BL        = 8,
  parameter int TRCD      = 15,
  parameter int TCL       = 15,
  parameter int TCWL      = 11,
  parameter int TRP       = 15,
  parameter int TRFC      = 64
) (
  input  logic                                 ck_t,
  input  logic                                 reset,
  ddr4_cmd_decoder_if.slave                    ca,
  output logic                                 cmd_valid,
  output cmd_t                                 cmd,
  output logic [BGWIDTH+BAWIDTH-1:0]           cmd_bank,
  output logic [ADDRWIDTH-1:0]                 cmd_row,
  output logic [COLWIDTH-1:0]                  cmd_col,
  output logic                                 err,
`ifdef DDR4_CA_PARITY_EN
  output logic                                 parity_err,
`endif
  output logic [(1<<(BGWIDTH+BAWIDTH))-1:0]    bank_open,
  output logic                                 rd_burst,
  output logic                                 wr_burst,
  output logic [$clog2(BL)-1:0]                burst_beat,
  output logic [BGWIDTH+BAWIDTH-1:0]           burst_bank,
  output logic [COLWIDTH-1:0]                  burst_col
);

  localparam int NB    = BGWIDTH + BAWIDTH;
  localparam int NBANK = 1 << NB;
  localparam int BW    = $clog2(BL);
  localparam int DW    = $clog2((TCL > TCWL) ? TCL : TCWL);
  localparam int RW    = $clog2(TRFC + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BL - 1);

  bank_state_t       st [NBANK];
  logic [NBANK-1:0]  act_vec, pre_vec, ap_vec;
  logic [NB-1:0]     bank_idx;
  bank_state_t       sel_st;
  logic              sel, all_idle, any_actv, ref_busy, ok, par_bad;
  logic              accept, reject, col_busy, burst_end;
  cmd_t              dec;

  logic [RW-1:0]       ref_cnt;
  logic                pend, burst_on, op_rd, op_ap;
  logic [NB-1:0]       op_bank;
  logic [COLWIDTH-1:0] op_col;
  logic [DW-1:0]       dly;
  logic [BW-1:0]       beat;

  assign sel      = ca.cke && !ca.cs_n;
  assign bank_idx = {ca.bg, ca.ba};
  assign sel_st   = st[bank_idx];
  assign ref_busy = (ref_cnt != '0);
  assign col_busy = pend || burst_on;

  always_comb begin
    dec = NOP;
    if (sel) begin
      if (!ca.act_n) begin
        dec = ACT;
      end else begin
        case ({ca.A[RAS_BIT], ca.A[CAS_BIT], ca.A[WE_BIT]})
          3'b000:  dec = MRS;
          3'b001:  dec = REF;
          3'b010:  dec = ca.A[AP_BIT] ? PREA : PRE;
          3'b100:  dec = WR;
          3'b101:  dec = RD;
          default: dec = NOP;
        endcase
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    any_actv = 1'b0;
    for (int i = 0; i < NBANK; i++) begin
      if (st[i] != IDLE)       all_idle = 1'b0;
      if (st[i] == ACTIVATING) any_actv = 1'b1;
    end
  end

  // Refresh blocks every non-NOP command, so it is folded into each rule.
  always_comb begin
    ok = 1'b1;
    case (dec)
      ACT:     ok = !ref_busy && (sel_st == IDLE);
      RD, WR:  ok = !ref_busy && (sel_st == ACTIVE) && !col_busy;
      PRE:     ok = !ref_busy && (sel_st != ACTIVATING);
      PREA:    ok = !ref_busy && !any_actv;
      REF:     ok = !ref_busy && all_idle;
      MRS:     ok = !ref_busy && all_idle;
      default: ok = 1'b1;
    endcase
  end

`ifdef DDR4_CA_PARITY_EN
  assign par_bad = sel && ((^{ca.act_n, ca.A, ca.bg, ca.ba}) != ca.parity);
`else
  assign par_bad = 1'b0;
`endif

  assign accept    = (dec != NOP) && ok  && !par_bad;
  assign reject    = (dec != NOP) && !ok && !par_bad;
  assign burst_end = burst_on && (beat == LAST_BEAT);

  for (genvar g = 0; g < NBANK; g++) begin : g_bank
    assign act_vec[g] = accept && (dec == ACT) && (bank_idx == NB'(g));
    assign pre_vec[g] = accept && ((dec == PREA) || ((dec == PRE) && (bank_idx == NB'(g))));
    assign ap_vec[g]  = ca.cke && burst_end && op_ap && (op_bank == NB'(g));

    ddr4_bank_fsm #(
      .TRCD (TRCD),
      .TRP  (TRP)
    ) u_bank (
      .clk   (ck_t),
      .reset (reset),
      .en    (ca.cke),
      .act   (act_vec[g]),
      .pre   (pre_vec[g] || ap_vec[g]),
      .state (st[g])
    );

    assign bank_open[g] = (st[g] == ACTIVE);
  end

  always_ff @(posedge ck_t) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      err        <= 1'b0;
`ifdef DDR4_CA_PARITY_EN
      parity_err <= 1'b0;
`endif
      cmd        <= NOP;
      cmd_bank   <= '0;
      cmd_row    <= '0;
      cmd_col    <= '0;
      ref_cnt    <= '0;
      pend       <= 1'b0;
      burst_on   <= 1'b0;
      op_rd      <= 1'b0;
      op_ap      <= 1'b0;
      op_bank    <= '0;
      op_col     <= '0;
      dly        <= '0;
      beat       <= '0;
    end else begin
      cmd_valid  <= 1'b0;
      err        <= 1'b0;
`ifdef DDR4_CA_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (ca.cke) begin
        cmd_valid  <= accept;
        err        <= reject;
`ifdef DDR4_CA_PARITY_EN
        parity_err <= par_bad;
`endif
        if (accept) begin
          cmd      <= dec;
          cmd_bank <= bank_idx;
          cmd_row  <= ca.A;
          cmd_col  <= ca.A[COLWIDTH-1:0];
        end

        if (accept && (dec == REF)) ref_cnt <= RW'(TRFC - 1);
        else if (ref_busy)          ref_cnt <= ref_cnt - 1'b1;

        if (burst_on) begin
          if (burst_end) begin
            burst_on <= 1'b0;
            beat     <= '0;
          end else begin
            beat <= beat + 1'b1;
          end
        end

        // Latency counter loads two short: one edge for acceptance, one for
        // the registered burst flag, so the first beat lands on T+TCL/TCWL.
        if (pend) begin
          if (dly == '0) begin
            pend     <= 1'b0;
            burst_on <= 1'b1;
            beat     <= '0;
          end else begin
            dly <= dly - 1'b1;
          end
        end

        if (accept && ((dec == RD) || (dec == WR))) begin
          pend    <= 1'b1;
          op_rd   <= (dec == RD);
          op_ap   <= ca.A[AP_BIT];
          op_bank <= bank_idx;
          op_col  <= ca.A[COLWIDTH-1:0];
          dly     <= (dec == RD) ? DW'(TCL - 2) : DW'(TCWL - 2);
        end
      end
    end
  end

  assign rd_burst   = burst_on && op_rd;
  assign wr_burst   = burst_on && !op_rd;
  assign burst_beat = beat;
  assign burst_bank = burst_on ? op_bank : '0;
  assign burst_col  = burst_on ? (op_col + COLWIDTH'(beat)) : '0;

endmodule

// File: tb/tb_ddr4_cmd_decoder.sv
// Directed bench for ddr4_cmd_decoder with hand-computed cycle expectations.
module tb_ddr4_cmd_decoder;
  import ddr4_pkg::*;

  logic        ck_t = 1'b0;
  logic        reset;
  logic        cmd_valid, err, rd_burst, wr_burst;
  cmd_t        cmd;
  logic [3:0]  cmd_bank, burst_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col, burst_col;
  logic [15:0] bank_open;
  logic [2:0]  burst_beat;
`ifdef DDR4_CA_PARITY_EN
  logic        parity_err;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ta, tw, tr, tq, tf, te;
  logic par_flip = 1'b0;

  always #5 ck_t = ~ck_t;

  ddr4_cmd_decoder_if #(.BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(17)) ca ();

  ddr4_cmd_decoder dut (
    .ck_t       (ck_t),
    .reset      (reset),
    .ca         (ca),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_bank   (cmd_bank),
    .cmd_row    (cmd_row),
    .cmd_col    (cmd_col),
    .err        (err),
`ifdef DDR4_CA_PARITY_EN
    .parity_err (parity_err),
`endif
    .bank_open  (bank_open),
    .rd_burst   (rd_burst),
    .wr_burst   (wr_burst),
    .burst_beat (burst_beat),
    .burst_bank (burst_bank),
    .burst_col  (burst_col)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck_t);
    cyc++;
    #1;
  endtask

  task automatic goto(input int e);
    while (cyc < e) tick();
  endtask

  task automatic deselect();
    ca.cs_n   = 1'b1;
    ca.act_n  = 1'b1;
    ca.A      = '0;
    ca.bg     = '0;
    ca.ba     = '0;
    ca.parity = 1'b0;
  endtask

  function automatic logic [16:0] cab(input logic [2:0] rcw, input logic ap, input logic [9:0] col);
    logic [16:0] a;
    a        = '0;
    a[16:14] = rcw;
    a[10]    = ap;
    a[9:0]   = col;
    return a;
  endfunction

  // Drives one command so it is sampled at the next edge, then deselects.
  task automatic issue(input logic actn, input logic [16:0] a, input logic [3:0] bk);
    ca.cs_n   = 1'b0;
    ca.act_n  = actn;
    ca.A      = a;
    ca.bg     = bk[3:2];
    ca.ba     = bk[1:0];
    ca.parity = (^{actn, a, bk}) ^ par_flip;
    tick();
    deselect();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_err"},       32'(err), 32'd0);
    chk({tag, "_cmd"},       32'(cmd), 32'd0);
    chk({tag, "_cmd_bank"},  32'(cmd_bank), 32'd0);
    chk({tag, "_cmd_row"},   32'(cmd_row), 32'd0);
    chk({tag, "_cmd_col"},   32'(cmd_col), 32'd0);
    chk({tag, "_bank_open"}, 32'(bank_open), 32'd0);
    chk({tag, "_rd_burst"},  32'(rd_burst), 32'd0);
    chk({tag, "_wr_burst"},  32'(wr_burst), 32'd0);
    chk({tag, "_beat"},      32'(burst_beat), 32'd0);
    chk({tag, "_bbank"},     32'(burst_bank), 32'd0);
    chk({tag, "_bcol"},      32'(burst_col), 32'd0);
`ifdef DDR4_CA_PARITY_EN
    chk({tag, "_parity_err"}, 32'(parity_err), 32'd0);
`endif
  endtask

  initial begin
    reset  = 1'b1;
    ca.cke = 1'b1;
    deselect();
    tick();
    tick();
    chk_zero("rst");
    reset = 1'b0;

    issue(1'b1, cab(3'b000, 1'b0, 10'd0), 4'd0);
    chk("mrs_valid", 32'(cmd_valid), 32'd1);
    chk("mrs_cmd",   32'(cmd), 32'(MRS));

    issue(1'b0, 17'd1, 4'd5);
    ta = cyc;
    chk("act_valid", 32'(cmd_valid), 32'd1);
    chk("act_cmd",   32'(cmd), 32'(ACT));
    chk("act_bank",  32'(cmd_bank), 32'd5);
    chk("act_row",   32'(cmd_row), 32'd1);
    chk("act_err",   32'(err), 32'd0);

    goto(ta + 9);
    issue(1'b1, cab(3'b101, 1'b0, 10'd0), 4'd5);
    chk("early_rd_err",   32'(err), 32'd1);
    chk("early_rd_valid", 32'(cmd_valid), 32'd0);

    goto(ta + 13);
    chk("open_before_trcd", 32'(bank_open), 32'h0000);
    tick();
    chk("open_at_trcd", 32'(bank_open), 32'h0020);

    issue(1'b1, cab(3'b100, 1'b0, 10'd0), 4'd5);
    tw = cyc;
    chk("wr_valid", 32'(cmd_valid), 32'd1);
    chk("wr_cmd",   32'(cmd), 32'(WR));

    goto(tw + 2);
    issue(1'b1, cab(3'b101, 1'b0, 10'd100), 4'd5);
    chk("busy_rd_err",   32'(err), 32'd1);
    chk("busy_rd_valid", 32'(cmd_valid), 32'd0);

    goto(tw + 9);
    chk("wr_pre_window",  32'(wr_burst), 32'd0);
    chk("early_rd_noburst", 32'(rd_burst), 32'd0);
    for (int i = 0; i < 8; i++) begin
      goto(tw + 10 + i);
      chk("wr_burst", 32'(wr_burst), 32'd1);
      chk("wr_rd_low", 32'(rd_burst), 32'd0);
      chk("wr_beat",  32'(burst_beat), 32'(i));
      chk("wr_col",   32'(burst_col), 32'(i));
      chk("wr_bank",  32'(burst_bank), 32'd5);
    end
    goto(tw + 18);
    chk("wr_post_window", 32'(wr_burst), 32'd0);

    goto(tw + 19);
    issue(1'b1, cab(3'b101, 1'b1, 10'd1020), 4'd5);
    tr = cyc;
    chk("rda_valid", 32'(cmd_valid), 32'd1);
    chk("rda_cmd",   32'(cmd), 32'(RD));
    chk("rda_col",   32'(cmd_col), 32'd1020);

    goto(tr + 13);
    chk("rd_pre_window", 32'(rd_burst), 32'd0);
    for (int i = 0; i < 8; i++) begin
      goto(tr + 14 + i);
      chk("rd_burst", 32'(rd_burst), 32'd1);
      chk("rd_beat",  32'(burst_beat), 32'(i));
      chk("rd_col",   32'(burst_col), 32'((1020 + i) % 1024));
      chk("rd_open",  32'(bank_open), 32'h0020);
    end
    goto(tr + 22);
    chk("rd_post_window", 32'(rd_burst), 32'd0);
    chk("ap_closed",      32'(bank_open), 32'h0000);

    goto(tr + 35);
    issue(1'b0, 17'd7, 4'd5);
    chk("act_in_trp_err",   32'(err), 32'd1);
    chk("act_in_trp_valid", 32'(cmd_valid), 32'd0);
    issue(1'b0, 17'd7, 4'd5);
    ta = cyc;
    chk("act_after_trp_valid", 32'(cmd_valid), 32'd1);
    chk("act_after_trp_row",   32'(cmd_row), 32'd7);

    issue(1'b1, cab(3'b010, 1'b1, 10'd0), 4'd0);
    chk("prea_actv_err", 32'(err), 32'd1);

    goto(ta + 14);
    chk("reopen", 32'(bank_open), 32'h0020);
    issue(1'b1, cab(3'b010, 1'b0, 10'd0), 4'd5);
    tq = cyc;
    chk("pre_valid", 32'(cmd_valid), 32'd1);
    chk("pre_cmd",   32'(cmd), 32'(PRE));
    chk("pre_closed", 32'(bank_open), 32'h0000);

    issue(1'b1, cab(3'b101, 1'b0, 10'd0), 4'd0);
    chk("rd_idle_err", 32'(err), 32'd1);

    goto(tq + 14);
    issue(1'b1, cab(3'b001, 1'b0, 10'd0), 4'd0);
    tf = cyc;
    chk("ref_valid", 32'(cmd_valid), 32'd1);
    chk("ref_cmd",   32'(cmd), 32'(REF));

    goto(tf + 9);
    issue(1'b1, cab(3'b000, 1'b0, 10'd0), 4'd0);
    chk("mrs_in_ref_err", 32'(err), 32'd1);

    goto(tf + 62);
    issue(1'b0, 17'h1abcd, 4'd2);
    chk("act_in_ref_err", 32'(err), 32'd1);
    issue(1'b0, 17'h1abcd, 4'd2);
    ta = cyc;
    chk("act_after_ref_valid", 32'(cmd_valid), 32'd1);
    chk("act_after_ref_row",   32'(cmd_row), 32'h1abcd);
    chk("act_after_ref_bank",  32'(cmd_bank), 32'd2);

    goto(ta + 14);
    issue(1'b1, cab(3'b101, 1'b0, 10'd3), 4'd2);
    tr = cyc;
    chk("rd2_valid", 32'(cmd_valid), 32'd1);
    goto(tr + 16);
    chk("rd2_mid",  32'(rd_burst), 32'd1);
    chk("rd2_beat", 32'(burst_beat), 32'd2);
    chk("rd2_col",  32'(burst_col), 32'd5);
    reset = 1'b1;
    tick();
    chk_zero("midburst_rst");
    reset = 1'b0;

    issue(1'b0, 17'd9, 4'd3);
    te = cyc;
    chk("act3_valid", 32'(cmd_valid), 32'd1);
    ca.cke = 1'b0;
    issue(1'b0, 17'd9, 4'd1);
    chk("cke0_valid", 32'(cmd_valid), 32'd0);
    chk("cke0_err",   32'(err), 32'd0);
    goto(te + 5);
    ca.cke = 1'b1;
    goto(te + 18);
    chk("frozen_trcd", 32'(bank_open), 32'h0000);
    tick();
    chk("thawed_trcd", 32'(bank_open), 32'h0008);

`ifdef DDR4_CA_PARITY_EN
    par_flip = 1'b1;
    issue(1'b0, 17'd1, 4'd0);
    par_flip = 1'b0;
    chk("par_err",   32'(parity_err), 32'd1);
    chk("par_valid", 32'(cmd_valid), 32'd0);
    chk("par_cerr",  32'(err), 32'd0);
    goto(cyc + 20);
    chk("par_bank_idle", 32'(bank_open), 32'h0008);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
